// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write side.
package regfile_pkg;

    localparam int REG_WIDTH    = 64;
    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_W   = $clog2(NUM_REGS);
    localparam int ZERO_REG_IDX = 31;

    typedef logic [REG_WIDTH-1:0]  reg_word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_write_port_decoder_n.sv
// Gate-level address decoder: a tree of 2:4 decoders (plus one 1:2 stage
// when the address width is odd), mirroring the 4:1 mux tree on the read side.
// The address is consumed MSB-first, so output index equals the address value.
// With en low every output is forced low regardless of the address bits.
module decoder_n #(
    parameter int ADDR_W  = 5,
    parameter int NUM_OUT = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0]  addr,
    input  logic               en,
    output logic [NUM_OUT-1:0] onehot
);

    localparam int  NUM_STAGES = (ADDR_W + 1) / 2;
    localparam bit  ODD_W      = (ADDR_W % 2) != 0;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int BITS     = (s == 0 && ODD_W) ? 1 : 2;
        localparam int CONSUMED = (s == 0) ? 0 : (ODD_W ? 2 * s - 1 : 2 * s);
        localparam int LO       = ADDR_W - CONSUMED - BITS;
        localparam int IN_W     = 1 << CONSUMED;
        localparam int OUT_W    = IN_W << BITS;

        logic [IN_W-1:0]  w_in;
        logic [OUT_W-1:0] w_out;

        if (s == 0) begin : g_root
            assign w_in = en;
        end else begin : g_chain
            assign w_in = g_stage[s-1].w_out;
        end

        if (BITS == 1) begin : g_dec12
            logic w_n0;
            not g_n0 (w_n0, addr[LO]);
            for (genvar j = 0; j < IN_W; j++) begin : g_leaf
                and g_a0 (w_out[2*j],   w_in[j], w_n0);
                and g_a1 (w_out[2*j+1], w_in[j], addr[LO]);
            end
        end else begin : g_dec24
            logic       w_n0;
            logic       w_n1;
            logic [3:0] w_dec;
            not g_n0 (w_n0, addr[LO]);
            not g_n1 (w_n1, addr[LO+1]);
            and g_d0 (w_dec[0], w_n1,       w_n0);
            and g_d1 (w_dec[1], w_n1,       addr[LO]);
            and g_d2 (w_dec[2], addr[LO+1], w_n0);
            and g_d3 (w_dec[3], addr[LO+1], addr[LO]);
            for (genvar j = 0; j < IN_W; j++) begin : g_node
                for (genvar k = 0; k < 4; k++) begin : g_leaf
                    and g_a (w_out[4*j+k], w_in[j], w_dec[k]);
                end
            end
        end
    end

    assign onehot = g_stage[NUM_STAGES-1].w_out;

endmodule : decoder_n

// File: rtl/regfile_write_port.sv
// Write side of the CPU register file: one-hot write decode, the register
// bank (with a hardwired-zero entry), a sticky per-register written mask,
// and a registered copy of the decoded enable for monitoring.
module regfile_write_port #(
    parameter int WIDTH    = regfile_pkg::REG_WIDTH,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::REG_ADDR_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG_IDX
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      clr_mask,
    output logic [NUM_REGS*WIDTH-1:0] regs_flat,
    output logic [NUM_REGS-1:0]       written,
    output logic [NUM_REGS-1:0]       wr_onehot
);

    import regfile_pkg::*;

    if ((1 << ADDR_W) != NUM_REGS) begin : g_bad_size
        $error("regfile_write_port: NUM_REGS must equal 2**ADDR_W");
    end
    if (ZERO_REG < 0 || ZERO_REG >= NUM_REGS) begin : g_bad_zero
        $error("regfile_write_port: ZERO_REG out of range");
    end

    localparam logic [NUM_REGS-1:0] ZERO_MASK = NUM_REGS'(1) << ZERO_REG;

    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_en;
    logic [NUM_REGS-1:0] r_written;
    logic [NUM_REGS-1:0] r_onehot;

    decoder_n #(
        .ADDR_W  (ADDR_W),
        .NUM_OUT (NUM_REGS)
    ) u_decoder (
        .addr   (wr_addr),
        .en     (wr_en),
        .onehot (w_dec)
    );

    // The zero register never receives an enable, so it is never written nor marked.
    assign w_en = w_dec & ~ZERO_MASK;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
        if (i == ZERO_REG) begin : g_zero
            assign regs_flat[i*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] r_q;

            // Enable DFF: load wr_data when this register is selected, else hold.
            // NOTE: the bank is architecturally cleared by reset, so every entry gets
            // a reset branch even though that is unusual for storage arrays.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_en[i]) begin
                    r_q <= wr_data;
                end
            end

            assign regs_flat[i*WIDTH +: WIDTH] = r_q;
        end
    end

    // Written mask: clear (if requested) then set the bit of this cycle's write.
    // NOTE: non-blocking assignments keep every flop reading pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_written <= '0;
        end else begin
            r_written <= (clr_mask ? '0 : r_written) | w_en;
        end
    end

    // Monitor copy of the decoded enable; zero on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_onehot <= '0;
        end else begin
            r_onehot <= w_en;
        end
    end

    assign written   = r_written;
    assign wr_onehot = r_onehot;

endmodule : regfile_write_port

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench: the driver updates an array model of the register file
// and queues the expected post-edge state; a monitor pops one entry after each
// rising edge and compares every register slice, the written mask and wr_onehot.
module tb_regfile_write_port;

    import regfile_pkg::*;

    localparam int W  = REG_WIDTH;
    localparam int N  = NUM_REGS;
    localparam int AW = REG_ADDR_W;
    localparam int ZR = ZERO_REG_IDX;

    typedef struct {
        reg_word_t       regs [N];
        logic [N-1:0]    written;
        logic [N-1:0]    onehot;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    reg_addr_t         wr_addr;
    reg_word_t         wr_data;
    logic              clr_mask;
    logic [N*W-1:0]    regs_flat;
    logic [N-1:0]      written;
    logic [N-1:0]      wr_onehot;

    int n_vec  = 0;
    int n_fail = 0;

    reg_word_t    m_regs [N];
    logic [N-1:0] m_written;
    exp_t         exp_q [$];

    always #5 clk = ~clk;

    regfile_write_port dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_mask  (clr_mask),
        .regs_flat (regs_flat),
        .written   (written),
        .wr_onehot (wr_onehot)
    );

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s[%0d] @%0t: got %h, expected %h", name, idx, $time, act, exp);
        end
    endtask

    // One stimulus cycle: drive at the falling edge, update the model, queue expectation.
    task automatic step(input logic rst, input logic we, input int addr,
                        input reg_word_t data, input logic clr);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        wr_en    = we;
        clr_mask = clr;
        if (we) begin
            wr_addr = reg_addr_t'(addr);
            wr_data = data;
        end else begin
            wr_addr = 'x;
            wr_data = 'x;
        end

        // No bypass: before the edge the target still shows its previous contents.
        if (!rst && we) begin
            #1;
            check("pre_edge_read", addr, regs_flat[addr*W +: W], m_regs[addr]);
        end

        e.onehot = '0;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_written = '0;
        end else begin
            if (clr) m_written = '0;
            if (we && addr != ZR) begin
                m_regs[addr]    = data;
                m_written[addr] = 1'b1;
                e.onehot        = N'(1) << addr;
            end
        end
        e.regs    = m_regs;
        e.written = m_written;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++)
                    check("reg", i, regs_flat[i*W +: W], e.regs[i]);
                check("written", 0, 64'(written), 64'(e.written));
                check("wr_onehot", 0, 64'(wr_onehot), 64'(e.onehot));
            end
        end
    end

    initial begin
        int budget;
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        clr_mask = 1'b0;
        foreach (m_regs[i]) m_regs[i] = '0;
        m_written = '0;

        // Reset held two cycles while a write is requested: reset wins.
        step(1, 1, 3, 64'hAA, 0);
        step(1, 1, 3, 64'hAA, 0);
        // Plain write.
        step(0, 1, 5, 64'h1234, 0);
        // Write to the zero register is dropped.
        step(0, 1, ZR, 64'hFFFF, 0);
        // Back-to-back writes to the same register.
        step(0, 1, 7, 64'h1, 0);
        step(0, 1, 7, 64'h2, 0);
        step(0, 0, 0, '0, 0);
        // Clear and write in the same cycle.
        step(0, 1, 2, 64'h55, 1);
        // Reset mid-stream while writing.
        step(0, 1, 9, 64'h99, 0);
        step(1, 1, 9, 64'hDEAD, 0);
        step(0, 0, 0, '0, 0);
        // Randomized sweep.
        for (int k = 0; k < 1000; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, N - 1)),
                 {$urandom, $urandom},
                 $urandom_range(0, 31) == 0);
        end

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_regfile_write_port
